axil_cmd_master: RTL

AXI4-Lite master bridge that turns a simple valid/ready command stream (one read or write per command) into single AXI4-Lite transactions. It sits directly upstream of the control-module/core top (cm_and_core) and drives its S_AXI slave port. Host-side logic (debug UART decoder, boot loader, PS glue) uses it to read and write core registers and control space. One outstanding transaction at a time. A cycle timeout guards against a hung slave.

---
 rtl/axil_cmd_master_if.sv | 37 +++
 rtl/axil_cmd_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
interface axil_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Command-stream to AXI4-Lite master bridge: one transaction in flight, with a hung-slave
// timeout that aborts the transfer and latches a sticky halted flag.
module axil_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    halted,
  axil_cmd_master_if.master       m_axi
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWr   = 3'd1;
  localparam logic [2:0] StWrB  = 3'd2;
  localparam logic [2:0] StRdAr = 3'd3;
  localparam logic [2:0] StRdR  = 3'd4;
  localparam logic [2:0] StRsp  = 3'd5;
  localparam logic [2:0] StHalt = 3'd6;

  logic [2:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  timeout_q, timeout_d;
  logic                  halted_q, halted_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic busy, expired, abort;

  assign aw_fire = awvalid_q && m_axi.awready;
  assign w_fire  = wvalid_q && m_axi.wready;
  assign b_fire  = bready_q && m_axi.bvalid;
  assign ar_fire = arvalid_q && m_axi.arready;
  assign r_fire  = rready_q && m_axi.rvalid;

  assign busy    = (state_q == StWr) || (state_q == StWrB) ||
                   (state_q == StRdAr) || (state_q == StRdR);
  // Limit is reached on the edge that would take the counter to TIMEOUT_CYCLES.
  assign expired = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    halted_d  = halted_q;
    cnt_d     = cnt_q;
    abort     = 1'b0;

    if (busy && (cnt_q != CntMax)) cnt_d = cnt_q + CntW'(1);

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          cnt_d     = '0;
          timeout_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end
        end
      end
      StWr: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if (!(awvalid_q && !aw_fire) && !(wvalid_q && !w_fire)) begin
          bready_d = 1'b1;
          state_d  = StWrB;
        end else if (!aw_fire && !w_fire && expired) begin
          abort = 1'b1;
        end
      end
      StWrB: begin
        if (b_fire) begin
          rdata_d  = '0;
          resp_d   = m_axi.bresp;
          bready_d = 1'b0;
          state_d  = StRsp;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRdAr: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRdR: begin
        if (r_fire) begin
          rdata_d  = m_axi.rdata;
          resp_d   = m_axi.rresp;
          rready_d = 1'b0;
          state_d  = StRsp;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = timeout_q ? StHalt : StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // Abort deliberately breaks the AXI protocol so a hung slave is visible upstream.
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b10;
      timeout_d = 1'b1;
      halted_d  = 1'b1;
      state_d   = StRsp;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StRsp);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;
  assign halted      = halted_q;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = rready_q;

endmodule
